digit_scan_mux: RTL and testbench

Time-multiplexed scanner for a 4-digit common-anode seven-segment display. Latches a 16-bit hex value, presents one 4-bit nibble at a time to the downstream `seven_seg` decoder's `Din`, and drives the matching active-low anode enable. Each digit is shown for a programmable number of clocks. New values are applied only at frame boundaries, so a frame never mixes digits from two different values.

---
 rtl/digit_scan_mux.sv | 146 ++++++++++++++
 tb/tb_digit_scan_mux.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/digit_scan_mux.sv
// digit_scan_mux: time-multiplexed scanner for a 4-digit common-anode
// seven-segment display. A 16-bit value is latched on `load` and shown one
// nibble at a time with an active-low one-hot anode enable. New values are
// committed only at frame boundaries, so a frame never mixes two values.
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading-zero
// digits (slots 1..3). Without it, `blank` is tied low and every slot drives
// its anode.
//
// `load` is a single-cycle strobe with no back-pressure: it is sampled on
// every rising edge and always accepted. The most recent load before a frame
// wrap wins; a load on the wrap edge itself goes straight to the display.
module digit_scan_mux #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        blank,
  output logic        frame_tick,
  output logic        pending
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);

  // Scan state
  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [15:0]   pend_val_q, pend_val_d;
  logic          pending_q, pending_d;

  // Registered display outputs
  logic [3:0]    digit_q, digit_d;
  logic [3:0]    an_q, an_d;
  logic          blank_q, blank_d;
  logic          frame_tick_q, frame_tick_d;

  logic          slot_end;
  logic          frame_wrap;
  logic          blank_now;

  // Prescaler, slot index and value staging (shadow / pending) next state
  always_comb begin
    pre_d      = pre_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    pend_val_d = pend_val_q;
    pending_d  = pending_q;

    slot_end   = (pre_q == PRE_MAX);
    frame_wrap = slot_end && (idx_q == 2'd3);

    if (slot_end) begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      pre_d = pre_q + 1'b1;
    end

    if (load && frame_wrap) begin
      // Load coinciding with the wrap bypasses the staging register.
      shadow_d   = value;
      pend_val_d = value;
      pending_d  = 1'b0;
    end else if (load) begin
      pend_val_d = value;
      pending_d  = 1'b1;
    end else if (frame_wrap && pending_q) begin
      shadow_d  = pend_val_q;
      pending_d = 1'b0;
    end
  end

  // Blank decision for the slot currently selected by idx_q
  always_comb begin
    blank_now = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (idx_q)
      2'd1:    blank_now = (shadow_q[15:4]  == 12'h000);
      2'd2:    blank_now = (shadow_q[15:8]  == 8'h00);
      2'd3:    blank_now = (shadow_q[15:12] == 4'h0);
      default: blank_now = 1'b0;
    endcase
`else
    blank_now = 1'b0;
`endif
  end

  // Output register inputs, derived from the current (pre-edge) state
  always_comb begin
    digit_d = shadow_q[3:0];
    case (idx_q)
      2'd0:    digit_d = shadow_q[3:0];
      2'd1:    digit_d = shadow_q[7:4];
      2'd2:    digit_d = shadow_q[11:8];
      default: digit_d = shadow_q[15:12];
    endcase
    an_d         = blank_now ? 4'b1111 : ~(4'b0001 << idx_q);
    blank_d      = blank_now;
    frame_tick_d = (idx_q == 2'd0) && (pre_q == '0);
  end

  // Scan state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q      <= '0;
      idx_q      <= 2'd0;
      shadow_q   <= 16'h0000;
      pend_val_q <= 16'h0000;
      pending_q  <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      pend_val_q <= pend_val_d;
      pending_q  <= pending_d;
    end
  end

  // Output register: keeps the anode drive glitch-free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q      <= 4'h0;
      an_q         <= 4'b1111;
      blank_q      <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      digit_q      <= digit_d;
      an_q         <= an_d;
      blank_q      <= blank_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign digit      = digit_q;
  assign an         = an_q;
  assign blank      = blank_q;
  assign frame_tick = frame_tick_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Bench for digit_scan_mux with REFRESH_DIV = 4. A reference model counts
// edges since reset release and derives slot, frame position and displayed
// value from plain arithmetic; expected outputs go into a queue and a
// negedge monitor compares them against the DUT.
module tb_digit_scan_mux;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        blank;
  logic        frame_tick;
  logic        pending;

  digit_scan_mux #(.REFRESH_DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .digit      (digit),
    .an         (an),
    .blank      (blank),
    .frame_tick (frame_tick),
    .pending    (pending)
  );

  // Clock
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Expected word: {an, digit, blank, frame_tick, pending}
  logic [10:0] exp_q[$];

  // Reference model state
  int          cyc;       // edges since reset release
  logic [15:0] m_shadow;
  logic [15:0] m_pend_val;
  logic        m_pend;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_blank(input logic [15:0] shadow, input int slot);
`ifdef LEADING_ZERO_BLANK_EN
    if (slot == 0) return 1'b0;
    return ((shadow >> (4 * slot)) == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    exp_q.delete();
    cyc        = 0;
    m_shadow   = 16'h0;
    m_pend_val = 16'h0;
    m_pend     = 1'b0;
  endtask

  // Reference model: at each edge predict the registered outputs from the
  // pre-edge frame position, then apply this edge's load.
  always @(posedge clk) begin
    if (!rst) begin
      int   slot;
      logic bl;
      logic [3:0] e_an;
      logic [3:0] e_dig;
      logic wrap;
      slot  = (cyc / DIV) % 4;
      bl    = model_blank(m_shadow, slot);
      e_an  = bl ? 4'b1111 : ~(4'(1) << slot);
      e_dig = 4'((m_shadow >> (4 * slot)) & 16'hF);
      wrap  = ((cyc % FRAME) == FRAME - 1);
      if (load && wrap) begin
        m_shadow = value;
        m_pend   = 1'b0;
      end else if (load) begin
        m_pend_val = value;
        m_pend     = 1'b1;
      end else if (wrap && m_pend) begin
        m_shadow = m_pend_val;
        m_pend   = 1'b0;
      end
      exp_q.push_back({e_an, e_dig, bl, (cyc % FRAME) == 0, m_pend});
      cyc++;
    end
  end

  // Monitor: one expected entry per active edge
  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      logic [10:0] e;
      e = exp_q.pop_front();
      check("an",         16'(an),         16'(e[10:7]));
      check("digit",      16'(digit),      16'(e[6:3]));
      check("blank",      16'(blank),      16'(e[2]));
      check("frame_tick", 16'(frame_tick), 16'(e[1]));
      check("pending",    16'(pending),    16'(e[0]));
    end
  end

  // Driver tasks (all start and end at a negedge)
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v);
    load  = 1'b1;
    value = v;
    @(negedge clk);
    load  = 1'b0;
  endtask

  // Wait until the next edge is at frame position p (bounded)
  task automatic wait_pos(input int p);
    int n;
    n = 0;
    while ((cyc % FRAME) != p && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check("wait_pos_timeout", 16'((cyc % FRAME) != p), 16'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"},      16'(an),         16'hF);
    check({tag, "_digit"},   16'(digit),      16'h0);
    check({tag, "_blank"},   16'(blank),      16'h0);
    check({tag, "_tick"},    16'(frame_tick), 16'h0);
    check({tag, "_pending"}, 16'(pending),    16'h0);
  endtask

  initial begin
    rst   = 1'b1;
    load  = 1'b0;
    value = 16'h0;
    model_reset();

    // Reset hold
    #1;
    check_reset_outputs("rst_hold0");
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_hold");
    rst = 1'b0;

    // Load mid-frame, then watch it arrive at the next wrap
    idle(6);
    do_load(16'h1234);
    idle(2 * FRAME);

    // Two loads in one frame: only the last is ever displayed
    wait_pos(2);
    do_load(16'hAAAA);
    idle(3);
    do_load(16'hBEEF);
    idle(2 * FRAME);

    // Load landing exactly on the wrap edge
    wait_pos(FRAME - 1);
    do_load(16'h5678);
    idle(FRAME + 3);

    // Leading-zero value
    do_load(16'h0042);
    idle(2 * FRAME + 2);

    // Random loads
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        logic [15:0] rv;
        rv = 16'($urandom);
        if ($urandom_range(0, 3) == 0) rv = rv & 16'h00FF;
        do_load(rv);
      end else begin
        idle(1);
      end
    end

    // Async reset in slot 2 with a value pending
    do_load(16'h9ABC);
    wait_pos(2 * DIV + 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    check_reset_outputs("async_rst_hold");
    rst = 1'b0;
    idle(2 * FRAME + 2);

    do_load(16'hF00D);
    idle(2 * FRAME + 2);

    check("queue_drained", 16'(exp_q.size() > 1), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
